// File: rtl/camera_pkg.sv
// Shared types and default timing for the OV7670-style camera stream path.
package camera_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } stream_state_t;

    localparam int DEF_H_ACTIVE    = 320;
    localparam int DEF_V_ACTIVE    = 240;
    localparam int DEF_H_BLANK     = 144;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;

    localparam int FB_ADDR_W = 17;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cam_line_timer.sv
// Horizontal and per-phase line counters. Exposes the counter values the next
// cycle will hold so the top can register its outputs against them.
module cam_line_timer #(
    parameter int LINE_LEN = 784,
    parameter int H_W      = 10,
    parameter int L_W      = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [L_W-1:0] phase_lines,
    output logic [H_W-1:0] h_nxt,
    output logic [L_W-1:0] line_nxt,
    output logic           phase_end
);

    localparam logic [H_W-1:0] H_LAST = H_W'(LINE_LEN - 1);

    logic [H_W-1:0] h_cnt;
    logic [L_W-1:0] line_cnt;
    logic           line_end;

    always_comb begin
        line_end  = run && (h_cnt == H_LAST);
        phase_end = line_end && (line_cnt == phase_lines - L_W'(1));
        h_nxt     = (run && !line_end) ? h_cnt + H_W'(1) : '0;
        if (phase_end)
            line_nxt = '0;
        else if (line_end)
            line_nxt = line_cnt + L_W'(1);
        else
            line_nxt = line_cnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt    <= '0;
            line_cnt <= '0;
        end else begin
            h_cnt    <= h_nxt;
            line_cnt <= line_nxt;
        end
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// Replays a frame memory as an OV7670-style vsync/href/byte stream.
// Every output is a flop loaded from the state and counters of the coming cycle.
module ov7670_stream_gen
    import camera_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    output logic                 oe,
    output logic [FB_ADDR_W-1:0] rAddr,
    input  logic [15:0]          rData,
    output logic                 vsync,
    output logic                 href,
    output logic [7:0]           data,
    output logic                 frame_done
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int H_W      = cnt_width(LINE_LEN);
    localparam int L_W      = cnt_width(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

    localparam logic [H_W-1:0] H_LAST      = H_W'(LINE_LEN - 1);
    localparam logic [H_W-1:0] H_PREFETCH  = H_W'(LINE_LEN - 2);
    localparam logic [H_W-1:0] H_HREF_END  = H_W'(2 * H_ACTIVE);
    localparam logic [H_W-1:0] H_READ_END  = H_W'(2 * H_ACTIVE - 2);
    localparam logic [L_W-1:0] VB_LAST     = L_W'(V_BACK - 1);
    localparam logic [L_W-1:0] VA_LAST     = L_W'(V_ACTIVE - 1);
    localparam logic [L_W-1:0] VF_LAST     = L_W'(V_FRONT - 1);
    localparam logic [FB_ADDR_W-1:0] PIX_LAST = FB_ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    stream_state_t  state, state_d;
    logic [L_W-1:0] phase_lines;
    logic [H_W-1:0] h_nxt;
    logic [L_W-1:0] line_nxt;
    logic           phase_end;

    logic           vsync_d, href_d, oe_d, frame_done_d;
    logic [7:0]     low_q;

    always_comb begin
        phase_lines = L_W'(1);
        unique case (state)
            ST_VSYNC:  phase_lines = L_W'(VSYNC_LINES);
            ST_VBACK:  phase_lines = L_W'(V_BACK);
            ST_ACTIVE: phase_lines = L_W'(V_ACTIVE);
            ST_VFRONT: phase_lines = L_W'(V_FRONT);
            default:   phase_lines = L_W'(1);
        endcase
    end

    cam_line_timer #(
        .LINE_LEN (LINE_LEN),
        .H_W      (H_W),
        .L_W      (L_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .run         (state != ST_IDLE),
        .phase_lines (phase_lines),
        .h_nxt       (h_nxt),
        .line_nxt    (line_nxt),
        .phase_end   (phase_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    // en is only consulted in IDLE and at the very end of a frame
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (en)        state_d = ST_VSYNC;
            ST_VSYNC:  if (phase_end) state_d = ST_VBACK;
            ST_VBACK:  if (phase_end) state_d = ST_ACTIVE;
            ST_ACTIVE: if (phase_end) state_d = ST_VFRONT;
            ST_VFRONT: if (phase_end) state_d = en ? ST_VSYNC : ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Pixel k of a line is read two cycles before its high byte; pixel 0
    // therefore lands in the previous line's blanking (or the last VBACK line).
    always_comb begin
        vsync_d      = (state_d == ST_VSYNC);
        href_d       = (state_d == ST_ACTIVE) && (h_nxt < H_HREF_END);
        frame_done_d = (state_d == ST_VFRONT) && (h_nxt == H_LAST) && (line_nxt == VF_LAST);
        oe_d         = ((state_d == ST_ACTIVE) && !h_nxt[0] && (h_nxt < H_READ_END))
                    || ((h_nxt == H_PREFETCH)
                        && (((state_d == ST_VBACK) && (line_nxt == VB_LAST))
                         || ((state_d == ST_ACTIVE) && (line_nxt != VA_LAST))));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            oe         <= 1'b0;
            frame_done <= 1'b0;
            data       <= '0;
            low_q      <= '0;
            rAddr      <= '0;
        end else begin
            vsync      <= vsync_d;
            href       <= href_d;
            oe         <= oe_d;
            frame_done <= frame_done_d;

            if (href_d) begin
                if (!h_nxt[0]) begin
                    data  <= rData[15:8];
                    low_q <= rData[7:0];
                end else begin
                    data  <= low_q;
                end
            end else begin
                data <= '0;
            end

            // Address holds at the last pixel once the frame's reads are done
            if ((state_d == ST_VSYNC) && (state != ST_VSYNC))
                rAddr <= '0;
            else if (oe && (rAddr != PIX_LAST))
                rAddr <= rAddr + FB_ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen with small frame parameters and a frame-position
// reference model.
module tb_ov7670_stream_gen;

    localparam int H_A   = 4;
    localparam int V_A   = 2;
    localparam int H_B   = 4;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int LL    = 2 * H_A + H_B;
    localparam int FRAME = (VS + VB + V_A + VF) * LL;

    logic        clk;
    logic        reset;
    logic        en;
    logic        oe;
    logic [16:0] rAddr;
    logic [15:0] rData;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;

    int n_cmp;
    int n_fail;

    ov7670_stream_gen #(
        .H_ACTIVE    (H_A),
        .V_ACTIVE    (V_A),
        .H_BLANK     (H_B),
        .VSYNC_LINES (VS),
        .V_BACK      (VB),
        .V_FRONT     (VF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .oe         (oe),
        .rAddr      (rAddr),
        .rData      (rData),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .frame_done (frame_done)
    );

    // ---------------- clock / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data outside a read's response cycle is junk, so misuse shows up
    always @(posedge clk)
        rData <= oe ? (16'hA000 + 16'(rAddr)) : 16'($urandom);

    // ---------------- reference model ----------------
    bit m_run;
    int m_f;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run <= 1'b0;
            m_f   <= 0;
        end else if (!m_run) begin
            if (en) begin
                m_run <= 1'b1;
                m_f   <= 0;
            end
        end else if (m_f == FRAME - 1) begin
            if (en) m_f <= 0;
            else    m_run <= 1'b0;
        end else begin
            m_f <= m_f + 1;
        end
    end

    function automatic bit m_vsync(int f);
        return (f / LL) < VS;
    endfunction

    function automatic bit m_href(int f);
        int al;
        al = f / LL - (VS + VB);
        return (al >= 0) && (al < V_A) && ((f % LL) < 2 * H_A);
    endfunction

    function automatic logic [7:0] m_data(int f);
        int al, h;
        logic [15:0] px;
        if (!m_href(f)) return 8'h00;
        al = f / LL - (VS + VB);
        h  = f % LL;
        px = 16'hA000 + 16'(al * H_A + h / 2);
        return (h % 2 == 0) ? px[15:8] : px[7:0];
    endfunction

    // A read at f serves the high byte shown at f+2
    function automatic bit m_oe(int f);
        int g, al, k2;
        g  = f + 2;
        al = g / LL - (VS + VB);
        k2 = g % LL;
        return (al >= 0) && (al < V_A) && (k2 % 2 == 0) && (k2 / 2 < H_A);
    endfunction

    function automatic int m_addr(int f);
        int g;
        g = f + 2;
        return (g / LL - (VS + VB)) * H_A + (g % LL) / 2;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_run) begin
            check("vsync", 32'(vsync), 32'(m_vsync(m_f)));
            check("href", 32'(href), 32'(m_href(m_f)));
            check("data", 32'(data), 32'(m_data(m_f)));
            check("oe", 32'(oe), 32'(m_oe(m_f)));
            check("frame_done", 32'(frame_done), 32'(m_f == FRAME - 1));
            if (m_oe(m_f)) check("rAddr", 32'(rAddr), 32'(m_addr(m_f)));
        end else begin
            check("idle_outs", {26'd0, vsync, href, oe, frame_done, 2'b00} | 32'(data), 32'd0);
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) begin
            n = -1;
            check("frame_done_timeout", 32'd0, 32'd1);
        end
    endtask

    logic [7:0]  exp_q[$];
    logic [16:0] addr_q[$];
    int          oe_t_q[$];

    initial begin
        int n, n_vs, n_href, n_oe, c;
        logic [7:0] e;
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        en     = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(3);

        // Single frame from a one-cycle en pulse, with literal byte/address lists
        for (int l = 0; l < V_A; l++)
            for (int k = 0; k < H_A; k++) begin
                exp_q.push_back(8'hA0);
                exp_q.push_back(8'(l * H_A + k));
                addr_q.push_back(17'(l * H_A + k));
            end
        en = 1'b1;
        tick(1);
        en = 1'b0;
        n = 0; n_vs = 0; n_href = 0; n_oe = 0;
        do begin
            @(negedge clk);
            n++;
            if (vsync) n_vs++;
            if (oe) begin
                n_oe++;
                oe_t_q.push_back(n);
                if (addr_q.size() > 0) check("lit_addr", 32'(rAddr), 32'(addr_q.pop_front()));
            end
            if (href) begin
                if (n_href % 2 == 0 && oe_t_q.size() > 0)
                    check("oe_to_byte", 32'(n - oe_t_q.pop_front()), 32'd2);
                n_href++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("lit_byte", 32'(data), 32'(e));
                end
            end
        end while (!frame_done && n < 200);
        check("done_cycle", 32'(n), 32'd60);
        check("vsync_cycles", 32'(n_vs), 32'd12);
        check("href_cycles", 32'(n_href), 32'd16);
        check("oe_count", 32'(n_oe), 32'd8);
        check("bytes_left", 32'(exp_q.size()), 32'd0);
        tick(6);
        check("idle_after_frame", {28'd0, vsync, href, oe, frame_done}, 32'd0);

        // Three back-to-back frames
        tick(2);
        en = 1'b1;
        for (int fr = 0; fr < 3; fr++) begin
            wait_done(n);
            if (fr == 2) en = 1'b0;
            @(negedge clk);
            check("vsync_after_done", 32'(vsync), 32'(fr < 2));
        end
        tick(5);

        // en drops mid-frame: frame still runs to its end
        en = 1'b1;
        tick(20);
        en = 1'b0;
        c = 19;
        do begin
            @(negedge clk);
            c++;
        end while (!frame_done && c < 300);
        check("drop_done_cycle", 32'(c), 32'd60);
        tick(10);
        check("idle_after_drop", {28'd0, vsync, href, oe, frame_done}, 32'd0);

        // Reset inside href, then restart
        en = 1'b1;
        tick(30);
        #1 reset = 1'b0;
        #1;
        check("rst_href", 32'(href), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);
        check("rst_addr", 32'(rAddr), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        tick(1);
        reset = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!oe && c < 100);
        check("restart_oe_seen", 32'(oe), 32'd1);
        check("restart_addr", 32'(rAddr), 32'd0);
        wait_done(n);
        en = 1'b0;
        tick(5);

        // Randomized en / reset activity
        for (int s = 0; s < 14; s++) begin
            en = 1'($urandom_range(0, 1));
            tick($urandom_range(5, 90));
            if ($urandom_range(0, 5) == 0) begin
                reset = 1'b0;
                tick($urandom_range(1, 3));
                reset = 1'b1;
            end
        end
        en = 1'b0;
        tick(70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_stream_gen.md
# ov7670_stream_gen

Transmit-side counterpart of the OV7670 camera capture path. Reads a 320x240 RGB565 image from a synchronous-read frame memory and replays it as an OV7670-style parallel stream: `vsync` frame pulse, `href` line qualifier, and 8-bit data, high byte first. It sits in simulation benches and in on-board loopback builds, standing in for the sensor in front of the capture memory controller. All outputs are on `clk`; the receiver samples on the same clock.

## Interface
Parameters:
- `H_ACTIVE`, 320: pixels per line (2 bytes each).
- `V_ACTIVE`, 240: active lines per frame.
- `H_BLANK`, 144: cycles per line with `href` low; legal range ≥ 4.
- `VSYNC_LINES`, 3: lines with `vsync` high at frame start.
- `V_BACK`, 17: idle lines after vsync.
- `V_FRONT`, 10: idle lines after the last active line.

Ports:
- `clk`  in  1  system clock; one stream byte per cycle.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  level; while high, frames are generated back to back.
- `oe`  out  1  memory read strobe.
- `rAddr`  out  17  memory read address (pixel index).
- `rData`  in  16  RGB565 read data, valid the cycle after `oe`.
- `vsync`  out  1  frame sync, active high.
- `href`  out  1  line valid.
- `data`  out  8  stream byte.
- `frame_done`  out  1  one-cycle pulse on the last cycle of a frame.

## Operation
- `LINE_LEN` = 2·H_ACTIVE + H_BLANK cycles. Frame = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) lines.
- State machine (`IDLE`, `VSYNC`, `VBACK`, `ACTIVE`, `VFRONT`):
  - `IDLE` → `VSYNC` when `en` = 1.
  - `VSYNC` → `VBACK` → `ACTIVE` → `VFRONT`, each after its line count.
  - `VFRONT` end → `VSYNC` if `en` = 1, else `IDLE`.
- Horizontal counter `h_cnt` runs 0..LINE_LEN-1 in every non-IDLE state. Line counter increments at wrap.
- `vsync` = 1 for every cycle in `VSYNC`.
- In `ACTIVE`:
  - `href` = 1 for `h_cnt` < 2·H_ACTIVE, else 0.
  - Even `h_cnt`: `data` = pixel[15:8]. Odd `h_cnt`: `data` = pixel[7:0] (low byte held in an internal register).
  - `data` = 0 whenever `href` = 0.
- Address counter:
  - Cleared to 0 on entry to `VSYNC`.
  - Increments by 1 after each read; reaches H_ACTIVE·V_ACTIVE-1 on the final pixel.
  - Never wraps within a frame.
- `en` falling mid-frame: the current frame completes in full, then the block goes to `IDLE`. `en` is ignored except at frame boundaries and in `IDLE`.
- Reset, including mid-frame: state = `IDLE`, counters = 0, and all outputs (`oe`, `rAddr`, `vsync`, `href`, `data`, `frame_done`) = 0 immediately.

## Timing
- All outputs registered.
- For the line whose `href` rises at cycle T, pixel k is read with `oe` = 1 and `rAddr` = base+k at cycle T-2+2k. `rData` is captured at T-1+2k. The high byte is on `data` at T+2k and the low byte at T+1+2k.
- The first read of a line is issued in the preceding line's blanking, or in the last `VBACK` line for line 0. It is not issued during `VFRONT`.
- `oe` = 0 in every cycle without a read.
- `frame_done` = 1 exactly on the final `VFRONT` cycle; the next frame's `vsync` rises on the following cycle when `en` = 1.
- Latency from `en` rising in `IDLE` to `vsync` = 1: 1 cycle.

## Structure
- Package `camera_pkg` holds:
  - the state typedef `stream_state_t`;
  - default timing constants (H_ACTIVE, V_ACTIVE, blanking, VSYNC_LINES, porches);
  - `FB_ADDR_W` = 17.
- One sub-module, `cam_line_timer`, produces `h_cnt`, the line counter, and the end-of-line / end-of-phase strobes. The FSM, read pipeline, and byte mux stay in the top module.

## Test plan
Small parameters throughout: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1. This gives LINE_LEN=12 and a 60-cycle frame. Memory model returns 16'hA000 + addr.
- Single frame: `en` pulsed for 1 cycle → `vsync` high 12 cycles, `href` high 8 cycles on each of 2 lines. Bytes A0,00,A0,01,A0,02,A0,03, then A0,04…A0,07. `frame_done` at cycle 60, then `IDLE`.
- Read pipeline: each `oe` precedes its high byte by exactly 2 cycles. `rAddr` runs 0..7 with no gaps or repeats. `oe` count per frame = 8.
- Continuous: `en` held high for 3 frames → `vsync` rises on the cycle after each `frame_done`. `rAddr` restarts at 0 each frame.
- `en` drops at cycle 20 → frame runs to cycle 60, then all outputs stay 0.
- Reset asserted at cycle 30 (inside `href`) → all outputs 0 in the same cycle. After release with `en` = 1, the next frame starts from `rAddr` 0.
- Loopback: default parameters into the capture memory controller → captured memory equals the source image word-for-word (76800 pixels).
